// File: rtl/capi_priwmem.sv
// Dual-write, single-read priority memory: w0 always wins, w1 is handshaked with a single-entry ack slot.
// Optional CAPI_PRIWMEM_BYPASS_EN makes a same-cycle read/write collision return the new data.
module capi_priwmem #(
  parameter int width      = 1,
  parameter int addr_width = 1,
  parameter int aux_width  = 1,
  parameter int raux_width = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_w0_v,
  input  logic [addr_width-1:0] i_w0_a,
  input  logic [width-1:0]      i_w0_d,
  input  logic                  i_w1_v,
  output logic                  i_w1_r,
  input  logic [addr_width-1:0] i_w1_a,
  input  logic [width-1:0]      i_w1_d,
  input  logic [aux_width-1:0]  i_w1_aux,
  output logic                  o_w1_v,
  input  logic                  o_w1_r,
  output logic [aux_width-1:0]  o_w1_aux,
  input  logic                  i_rd_v,
  input  logic [addr_width-1:0] i_rd_a,
  input  logic [raux_width-1:0] i_rd_aux,
  output logic                  o_rd_v,
  output logic [width-1:0]      o_rd_d,
  output logic [raux_width-1:0] o_rd_aux
);
  localparam int depth = 1 << addr_width;

  logic [width-1:0]      mem [depth];
  logic                  ack_v_reg;
  logic [aux_width-1:0]  ack_aux_reg;
  logic                  rd_v_reg;
  logic [width-1:0]      rd_d_reg;
  logic [raux_width-1:0] rd_aux_reg;

  logic                  w1_accept;
  logic                  wr_en;
  logic [addr_width-1:0] wr_a;
  logic [width-1:0]      wr_d;

  // Ready is forced low while reset is held so nothing can be accepted.
  always_comb begin
    i_w1_r    = reset & ~i_w0_v & (~ack_v_reg | o_w1_r);
    w1_accept = i_w1_v & i_w1_r;
    wr_en     = reset & (i_w0_v | w1_accept);
    wr_a      = i_w0_v ? i_w0_a : i_w1_a;
    wr_d      = i_w0_v ? i_w0_d : i_w1_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_a] <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rd_v) begin
      rd_aux_reg <= i_rd_aux;
`ifdef CAPI_PRIWMEM_BYPASS_EN
      rd_d_reg   <= (wr_en && (wr_a == i_rd_a)) ? wr_d : mem[i_rd_a];
`else
      rd_d_reg   <= mem[i_rd_a];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w1_accept) begin
      ack_aux_reg <= i_w1_aux;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_v_reg <= 1'b0;
      rd_v_reg  <= 1'b0;
    end else begin
      // A drain and a new acceptance in the same cycle leave the slot full.
      ack_v_reg <= w1_accept | (ack_v_reg & ~o_w1_r);
      rd_v_reg  <= i_rd_v;
    end
  end

  assign o_w1_v   = ack_v_reg;
  assign o_w1_aux = ack_aux_reg;
  assign o_rd_v   = rd_v_reg;
  assign o_rd_d   = rd_d_reg;
  assign o_rd_aux = rd_aux_reg;
endmodule

// File: tb/tb_capi_priwmem.sv
// Scoreboard bench for capi_priwmem: directed scenarios plus random traffic checked against a reference model.
module tb_capi_priwmem;
  localparam int W = 8, AW = 4, XW = 4, RXW = 4, DEPTH = 16;

  logic clk = 1'b0, reset = 1'b0;
  logic i_w0_v = 0, i_w1_v = 0, o_w1_r = 0, i_rd_v = 0;
  logic [AW-1:0] i_w0_a = '0, i_w1_a = '0, i_rd_a = '0;
  logic [W-1:0]  i_w0_d = '0, i_w1_d = '0;
  logic [XW-1:0] i_w1_aux = '0;
  logic [RXW-1:0] i_rd_aux = '0;
  logic i_w1_r, o_w1_v, o_rd_v;
  logic [XW-1:0] o_w1_aux;
  logic [W-1:0]  o_rd_d;
  logic [RXW-1:0] o_rd_aux;

  capi_priwmem #(.width(W), .addr_width(AW), .aux_width(XW), .raux_width(RXW)) dut (
    .clk(clk), .reset(reset),
    .i_w0_v(i_w0_v), .i_w0_a(i_w0_a), .i_w0_d(i_w0_d),
    .i_w1_v(i_w1_v), .i_w1_r(i_w1_r), .i_w1_a(i_w1_a), .i_w1_d(i_w1_d), .i_w1_aux(i_w1_aux),
    .o_w1_v(o_w1_v), .o_w1_r(o_w1_r), .o_w1_aux(o_w1_aux),
    .i_rd_v(i_rd_v), .i_rd_a(i_rd_a), .i_rd_aux(i_rd_aux),
    .o_rd_v(o_rd_v), .o_rd_d(o_rd_d), .o_rd_aux(o_rd_aux)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int exp_rd_d[$];
  int exp_rd_x[$];
  int exp_ack[$];
  int m_mem [DEPTH];
  logic m_ack_v = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents one.
  always @(negedge clk) begin
    if (reset) begin
      if (o_rd_v) begin
        if (exp_rd_d.size() == 0) chk("rd_unexpected", 32'(o_rd_v), 32'd0);
        else begin
          chk("rd_data", 32'(o_rd_d), 32'(exp_rd_d.pop_front()));
          chk("rd_aux", 32'(o_rd_aux), 32'(exp_rd_x.pop_front()));
        end
      end
      if (o_w1_v && o_w1_r) begin
        if (exp_ack.size() == 0) chk("ack_unexpected", 32'(o_w1_v), 32'd0);
        else chk("ack_aux", 32'(o_w1_aux), 32'(exp_ack.pop_front()));
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input logic w0v, input int w0a, input int w0d,
                     input logic w1v, input int w1a, input int w1d, input int w1x,
                     input logic rv, input int ra, input int rx, input logic ar);
    logic exp_r, acc;
    int d;
    i_w0_v = w0v; i_w0_a = w0a[AW-1:0]; i_w0_d = w0d[W-1:0];
    i_w1_v = w1v; i_w1_a = w1a[AW-1:0]; i_w1_d = w1d[W-1:0]; i_w1_aux = w1x[XW-1:0];
    i_rd_v = rv;  i_rd_a = ra[AW-1:0];  i_rd_aux = rx[RXW-1:0];
    o_w1_r = ar;
    #1;
    exp_r = !w0v && (!m_ack_v || ar);
    chk("w1_ready", 32'(i_w1_r), 32'(exp_r));
    chk("w1_ack_v", 32'(o_w1_v), 32'(m_ack_v));
    acc = w1v && exp_r;
    if (rv) begin
      d = m_mem[ra];
`ifdef CAPI_PRIWMEM_BYPASS_EN
      if (w0v && w0a == ra) d = w0d;
      else if (acc && w1a == ra) d = w1d;
`endif
      exp_rd_d.push_back(d);
      exp_rd_x.push_back(rx);
    end
    if (acc) exp_ack.push_back(w1x);
    @(posedge clk);
    if (w0v) m_mem[w0a] = w0d;
    else if (acc) m_mem[w1a] = w1d;
    m_ack_v = acc ? 1'b1 : (ar ? 1'b0 : m_ack_v);
    #1;
  endtask

  task automatic idle(input logic ar);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ar);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1; o_w1_r = 1'b1;
    #1;
    chk("rst_o_w1_v", 32'(o_w1_v), 32'd0);
    chk("rst_o_rd_v", 32'(o_rd_v), 32'd0);
    chk("rst_i_w1_r", 32'(i_w1_r), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < DEPTH; a++) cyc(1, a, 8'h80 + a, 0, 0, 0, 0, 0, 0, 0, 0);

    // w1 write, ack, then read back
    cyc(0, 0, 0, 1, 3, 8'hA5, 2, 0, 0, 0, 0);
    chk("t1_ack_v", 32'(o_w1_v), 32'd1);
    chk("t1_ack_aux", 32'(o_w1_aux), 32'd2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 3, 5, 1);
    chk("t1_rd_d", 32'(o_rd_d), 32'hA5);
    chk("t1_rd_aux", 32'(o_rd_aux), 32'd5);

    // w0 and w1 to the same address: w0 wins, w1 retries
    cyc(1, 5, 8'h11, 1, 5, 8'h22, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 8'h22, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 1);
    chk("t2_rd_d", 32'(o_rd_d), 32'h22);

    // Ack backpressure, then drain and accept in the same cycle
    cyc(0, 0, 0, 1, 9, 8'h77, 4, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 10, 8'h88, 5, 0, 0, 0, 0);
    chk("t3_stall_r", 32'(i_w1_r), 32'd0);
    cyc(0, 0, 0, 1, 10, 8'h88, 5, 0, 0, 0, 0);
    chk("t3_stall_aux", 32'(o_w1_aux), 32'd4);
    cyc(0, 0, 0, 1, 10, 8'h88, 5, 0, 0, 0, 1);
    chk("t3_b2b_aux", 32'(o_w1_aux), 32'd5);
    idle(1);

    // Same-cycle read/write collision
    cyc(1, 7, 8'h33, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 8'h44, 0, 0, 0, 0, 1, 7, 6, 0);
`ifdef CAPI_PRIWMEM_BYPASS_EN
    chk("t4_collide", 32'(o_rd_d), 32'h44);
`else
    chk("t4_collide", 32'(o_rd_d), 32'h33);
`endif

    // Asynchronous reset with an ack pending and a read in flight
    cyc(0, 0, 0, 1, 11, 8'h55, 6, 1, 3, 7, 0);
    #1;
    reset = 1'b0;
    i_w1_v = 1'b1; i_w1_a = 4'd12; i_w1_d = 8'h66; i_rd_v = 1'b0; i_w0_v = 1'b0;
    #1;
    chk("t5_async_w1_v", 32'(o_w1_v), 32'd0);
    chk("t5_async_rd_v", 32'(o_rd_v), 32'd0);
    chk("t5_async_w1_r", 32'(i_w1_r), 32'd0);
    exp_rd_d.delete(); exp_rd_x.delete(); exp_ack.delete();
    m_ack_v = 1'b0;
    @(posedge clk); #1;
    i_w1_v = 1'b0; i_w0_v = 1'b1; i_w0_a = 4'd11; i_w0_d = 8'hFF;
    #1;
    chk("t5_rst_w1_r", 32'(i_w1_r), 32'd0);
    @(posedge clk); #2;
    i_w0_v = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 11, 2, 0);
    chk("t5_no_wr_w0", 32'(o_rd_d), 32'h55);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 3, 0);
    chk("t5_no_wr_w1", 32'(o_rd_d), 32'h8C);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
          $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
          $urandom_range(0, 15),
          $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 15),
          $urandom_range(0, 9) < 6);
    end
    repeat (3) idle(1);
    chk("drain_rd_q", 32'(exp_rd_d.size()), 32'd0);
    chk("drain_ack_q", 32'(exp_ack.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/capi_priwmem.md
Name: capi_priwmem

Overview:
- Dual write-port memory with a single read port. Write port 0 has absolute priority and is always accepted.
- Write port 1 is low priority, valid/ready handshaked, and returns a per-write completion (ack) carrying an aux tag.
- This is the write-side counterpart to the dual-read priority memory. It lets a fast-path writer and a background writer share one RAM that a pipeline stage reads with fixed latency.

Parameters:
- width, 1, data word width
- addr_width, 1, address width; depth = 2**addr_width
- aux_width, 1, width of port-1 write tag returned on ack
- raux_width, 1, width of read-side tag passed through with read data

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- i_w0_v  input  1  high-priority write request; no ready, always accepted
- i_w0_a  input  addr_width  port-0 write address
- i_w0_d  input  width  port-0 write data
- i_w1_v  input  1  low-priority write request valid
- i_w1_r  output  1  low-priority write ready
- i_w1_a  input  addr_width  port-1 write address
- i_w1_d  input  width  port-1 write data
- i_w1_aux  input  aux_width  port-1 tag
- o_w1_v  output  1  port-1 write completion valid
- o_w1_r  input  1  completion ready
- o_w1_aux  output  aux_width  tag of completed write
- i_rd_v  input  1  read request; no ready, always accepted
- i_rd_a  input  addr_width  read address
- i_rd_aux  input  raux_width  read tag
- o_rd_v  output  1  read data valid
- o_rd_d  output  width  read data
- o_rd_aux  output  raux_width  read tag, aligned with o_rd_d

Behaviour:
- Reset is asserted (reset=0) asynchronously. While asserted:
  - o_w1_v=0, o_rd_v=0, i_w1_r=0.
  - Ack register and read-valid register are cleared.
  - No memory write occurs.
  - Memory contents are not initialised.
  - o_rd_d, o_rd_aux and o_w1_aux are don't-care.
- Deassertion is used synchronously via the standard reset synchroniser upstream; the block assumes it is glitch-free.
- Arbitration is combinational in cycle t:
  - i_w1_r = ~i_w0_v & (~o_w1_v | o_w1_r).
  - The winner is w0 if i_w0_v; otherwise w1 if i_w1_v & i_w1_r.
  - At most one memory write per cycle.
  - The memory write commits at the clk edge ending cycle t.
- Port-1 acceptance sets the ack register at the end of cycle t, loading i_w1_aux.
  - o_w1_v=1 from cycle t+1 and holds, with o_w1_aux stable, until o_w1_r=1.
  - Completion means the data is visible to any read issued at or after t+1.
- Ack slot:
  - Single entry. A new w1 acceptance is allowed in the same cycle the current ack drains (o_w1_r=1), giving back-to-back throughput of 1/cycle.
  - If o_w1_v=1 and o_w1_r=0, then i_w1_r=0.
- Starvation: if w0 is valid every cycle, w1 is never accepted. This is by design; the upstream caller bounds w0 duty.
- Read path:
  - Read is issued in cycle t and the RAM reads at the edge ending t.
  - o_rd_v=1, o_rd_d and o_rd_aux appear in cycle t+1. Fixed 1-cycle latency.
  - No backpressure. o_rd_v is 0 in cycles with no read issued.
  - The aux register is enabled only on i_rd_v, so it holds its value otherwise.
- Read/write collision is the same address in the same cycle t. Behaviour is defined under Optional Feature.
  - A read in t+1 or later always returns the newly written data.
- Simultaneous w0 and w1 to the same address in the same cycle: w0 is written, w1 is not accepted (i_w1_r=0) and retries.
- Address arithmetic is modulo depth; no range checks.

Optional Feature:
- Macro: CAPI_PRIWMEM_BYPASS_EN.
- Defined:
  - A same-cycle collision between i_rd_a and the winning write address returns the winning write data (write-through).
  - The comparator and data mux are registered with the read output; latency is unchanged.
- Undefined:
  - A collision returns the old memory contents (read-before-write).
  - No comparator is synthesised.

Test Plan:
- Reset, then i_w1_v=1 (a=3, d=0xA5, aux=2), w0 idle -> i_w1_r=1 that cycle; o_w1_v=1, o_w1_aux=2 next cycle; a read of a=3 issued in the following cycle returns o_rd_d=0xA5 one cycle later.
- i_w0_v=1 (a=5, d=0x11) and i_w1_v=1 (a=5, d=0x22) in the same cycle -> i_w1_r=0; next cycle, with w0 idle, w1 is accepted; a subsequent read of a=5 returns 0x22.
- o_w1_r held 0 after one w1 write -> o_w1_v stays 1, o_w1_aux stable, i_w1_r=0. Raise o_w1_r with a new w1 pending -> ack drains and the new write is accepted in the same cycle.
- Write a=7 with 0x33, then read a=7 and write a=7 with 0x44 in the same cycle -> o_rd_d=0x33 without CAPI_PRIWMEM_BYPASS_EN, 0x44 with it.
- Reset asserted mid-stream while o_w1_v=1 and a read is in flight -> o_w1_v=0 and o_rd_v=0 immediately (asynchronous), i_w1_r=0 until release; no write commits during reset.
- Random w0/w1/read traffic for 10k cycles against a reference model -> every w1 aux is returned exactly once in order, every read returns model data, and o_rd_aux matches.
